// File: rtl/vending_controller.sv
// vending_controller
//   Vending transaction controller with NUM_CH money channels and a
//   NUM_GOODS price table. It handles goods selection, money accumulation
//   with overflow rejection, inactivity auto-cancel, and req/ack handshakes
//   toward the dispenser and the change payout mechanism.
//
// Ports
//   sys_clk       in   system clock, rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   money_pulse   in   [NUM_CH]  one-cycle insert pulses, one bit per channel
//   key_goods     in   advance goods selection (IDLE only)
//   key_confirm   in   confirm selection, IDLE -> PAY
//   key_cancel    in   abort purchase (PAY only)
//   dispense_ack  in   dispenser delivered goods
//   change_ack    in   payout mechanism returned change_money
//   goods_sel     out  selected goods index
//   need_money    out  price of goods_sel
//   input_money   out  accumulated inserted money
//   change_money  out  amount to return
//   state         out  IDLE=0, PAY=1, DISPENSE=2, CHANGE=3
//   dispense_req  out  request to dispense goods_sel
//   change_req    out  request to pay out change_money
//   money_reject  out  one-cycle pulse, insert dropped on overflow
module vending_controller #(
  parameter int NUM_CH    = 5,
  parameter int MONEY_W   = 8,
  parameter logic [NUM_CH*MONEY_W-1:0] CH_VALUES = {8'd50, 8'd20, 8'd10, 8'd5, 8'd1},
  parameter int NUM_GOODS = 4,
  parameter logic [NUM_GOODS*MONEY_W-1:0] PRICES = {8'd25, 8'd12, 8'd7, 8'd3},
  parameter int TIMEOUT   = 1_000_000,
  localparam int GW       = $clog2(NUM_GOODS),
  localparam int TW       = $clog2(TIMEOUT)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_CH-1:0]    money_pulse,
  input  logic                 key_goods,
  input  logic                 key_confirm,
  input  logic                 key_cancel,
  input  logic                 dispense_ack,
  input  logic                 change_ack,
  output logic [GW-1:0]        goods_sel,
  output logic [MONEY_W-1:0]   need_money,
  output logic [MONEY_W-1:0]   input_money,
  output logic [MONEY_W-1:0]   change_money,
  output logic [1:0]           state,
  output logic                 dispense_req,
  output logic                 change_req,
  output logic                 money_reject
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAY      = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_e;

  localparam int SW = MONEY_W + 3;  // per-cycle insert sum
  localparam int AW = MONEY_W + 4;  // accumulator + sum, room for carry

  state_e             state_q;
  logic [GW-1:0]      sel_q;
  logic [MONEY_W-1:0] need_q, in_q, chg_q;
  logic               dreq_q, creq_q, rej_q;
  logic [TW-1:0]      tmr_q;

  function automatic logic [MONEY_W-1:0] price(input logic [GW-1:0] g);
    return PRICES[MONEY_W*g +: MONEY_W];
  endfunction

  // Per-channel gated amounts, summed below.
  logic [NUM_CH-1:0][SW-1:0] ch_amt;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_amt[i] = money_pulse[i] ? SW'(CH_VALUES[MONEY_W*i +: MONEY_W]) : '0;
  end

  logic [SW-1:0]      sum;
  logic [AW-1:0]      total;
  logic               ovf, any_money, tmo;
  logic [MONEY_W-1:0] in_new;
  logic [GW-1:0]      sel_nxt;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) sum = sum + ch_amt[i];
    total     = AW'(in_q) + AW'(sum);
    // Anything above the MONEY_W range drops the whole cycle's insert.
    ovf       = |total[AW-1:MONEY_W];
    in_new    = ovf ? in_q : total[MONEY_W-1:0];
    any_money = |money_pulse;
    // Money activity in the same cycle restarts the idle window instead.
    tmo       = !any_money && (tmr_q == TW'(TIMEOUT - 1));
    sel_nxt   = (sel_q == GW'(NUM_GOODS - 1)) ? '0 : sel_q + GW'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      need_q  <= price('0);
      in_q    <= '0;
      chg_q   <= '0;
      dreq_q  <= 1'b0;
      creq_q  <= 1'b0;
      rej_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      rej_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Confirm outranks a same-cycle selection change.
          if (key_confirm) begin
            state_q <= S_PAY;
            in_q    <= '0;
            chg_q   <= '0;
            tmr_q   <= '0;
          end else if (key_goods) begin
            sel_q  <= sel_nxt;
            need_q <= price(sel_nxt);
          end
        end
        S_PAY: begin
          tmr_q <= any_money ? '0 : tmr_q + TW'(1);
          rej_q <= ovf;
          in_q  <= in_new;
          // Cancel/timeout outrank reaching the price; refund includes
          // money accepted this same cycle.
          if (key_cancel || tmo) begin
            if (in_new != '0) begin
              state_q <= S_CHANGE;
              chg_q   <= in_new;
              creq_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              in_q    <= '0;
              chg_q   <= '0;
            end
          end else if (in_new >= need_q) begin
            state_q <= S_DISPENSE;
            dreq_q  <= 1'b1;
          end
        end
        S_DISPENSE: begin
          if (dreq_q && dispense_ack) begin
            dreq_q <= 1'b0;
            if (in_q != need_q) begin
              state_q <= S_CHANGE;
              chg_q   <= in_q - need_q;
              creq_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              in_q    <= '0;
              chg_q   <= '0;
            end
          end
        end
        S_CHANGE: begin
          if (creq_q && change_ack) begin
            creq_q  <= 1'b0;
            state_q <= S_IDLE;
            in_q    <= '0;
            chg_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign goods_sel    = sel_q;
  assign need_money   = need_q;
  assign input_money  = in_q;
  assign change_money = chg_q;
  assign state        = state_q;
  assign dispense_req = dreq_q;
  assign change_req   = creq_q;
  assign money_reject = rej_q;

endmodule

// File: doc/vending_controller.md
# vending_controller

Parametrised vending transaction controller for the micro-vending design. It generalises the fixed five-denomination flow to NUM_CH money channels and a NUM_GOODS price table. It adds inactivity auto-cancel, overflow rejection, and req/ack handshakes toward the dispense and change-payout mechanisms. It sits between the debounced key/money pulses from key_filter and display_design, and supplies need_money, input_money and change_money to the display.

## Interface
- NUM_CH, 5, number of money channels
- CH_VALUES, {8'd50,8'd20,8'd10,8'd5,8'd1}, packed NUM_CH×MONEY_W values; channel i value = bits [MONEY_W*i +: MONEY_W]
- NUM_GOODS, 4, number of selectable goods (≥2)
- PRICES, {8'd25,8'd12,8'd7,8'd3}, packed NUM_GOODS×MONEY_W prices; goods i price = bits [MONEY_W*i +: MONEY_W], each nonzero
- MONEY_W, 8, width of all money quantities
- TIMEOUT, 1_000_000, idle cycles in PAY before auto-cancel (≥2)
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  reset, asynchronous, active-low
- money_pulse  in  NUM_CH  one-cycle debounced insert pulses, one bit per channel
- key_goods  in  1  one-cycle pulse, advance goods selection
- key_confirm  in  1  one-cycle pulse, confirm selection
- key_cancel  in  1  one-cycle pulse, abort purchase
- dispense_ack  in  1  dispenser has delivered goods
- change_ack  in  1  payout mechanism has returned change_money
- goods_sel  out  clog2(NUM_GOODS)  selected goods index
- need_money  out  MONEY_W  price of goods_sel
- input_money  out  MONEY_W  accumulated inserted money
- change_money  out  MONEY_W  amount to return
- state  out  2  IDLE=0, PAY=1, DISPENSE=2, CHANGE=3
- dispense_req  out  1  request to dispense goods_sel
- change_req  out  1  request to pay out change_money
- money_reject  out  1  one-cycle pulse, insert rejected (overflow)

## Operation
- Reset values: state IDLE, goods_sel 0, need_money PRICES[0], input_money 0, change_money 0, dispense_req 0, change_req 0, money_reject 0, timeout counter 0. Reset asserted in any state aborts the transaction immediately. No refund is issued.
- IDLE:
  - key_goods increments goods_sel, wrapping NUM_GOODS-1 → 0; need_money follows.
  - key_confirm → PAY. input_money and change_money are cleared on entry.
  - money_pulse is ignored, with no reject.
  - If key_goods and key_confirm arrive in the same cycle, confirm wins and the selection does not change.
- PAY:
  - All set money_pulse bits in a cycle are summed (width MONEY_W+3).
  - If input_money + sum > 2^MONEY_W−1, the whole cycle's insert is dropped and money_reject pulses. Otherwise input_money += sum.
  - key_goods is ignored.
  - Any money pulse, accepted or rejected, clears the timeout counter. Otherwise the counter increments each cycle.
  - If the new input_money ≥ need_money → DISPENSE.
  - key_cancel, or the counter reaching TIMEOUT−1 → CHANGE with change_money = new input_money (refund, including money accepted that same cycle). If the refund is zero → IDLE instead.
  - Cancel has priority over the DISPENSE transition.
- DISPENSE:
  - dispense_req is held high until dispense_ack is sampled high.
  - On that ack, change_money = input_money − need_money; go to CHANGE if nonzero, else IDLE.
  - key_cancel and money are ignored.
- CHANGE:
  - change_req is held high until change_ack is sampled high, then → IDLE.
  - On entering IDLE, input_money and change_money are cleared.
  - goods_sel is retained across transactions.
- An ack while the corresponding req is low is ignored.

## Timing
- All outputs are registered.
- Money pulse at edge t: input_money is updated after edge t. The state change caused by it is visible in the same cycle, and money_reject is high for exactly one cycle.
- PAY → DISPENSE: dispense_req is high in the first DISPENSE cycle.
- Ack sampled at edge t: req is low after edge t, and the next state is visible in the same cycle.
- A minimum transaction is IDLE → PAY → DISPENSE → IDLE in 3 edges after confirm, given immediate money and ack.
- The timeout fires exactly TIMEOUT cycles after the last money pulse or after PAY entry.

## Test plan
- Reset, then 2× key_goods, then confirm → goods_sel=2, need_money=12, state=PAY. Next, money_pulse channel 2 (10), then channel 1 (5) → input_money=15, state=DISPENSE. dispense_ack → change_money=3, change_req=1. change_ack → IDLE, all money zero.
- Select goods 0 (price 3), confirm, then three separate 1-pulses → DISPENSE with no change. Ack → IDLE directly; change_req is never asserted. Then 4× key_goods wraps goods_sel back to 0.
- PAY with goods 3, insert 20, then key_cancel → CHANGE, change_money=20, dispense_req never high. Repeat with cancel in the same cycle as a 50 insert → refund 70.
- Set PRICES[3]=250 and insert 4×50=200. Then a simultaneous 50+20 pulse → money_reject for 1 cycle, input_money stays 200. Then insert 50 → DISPENSE.
- With TIMEOUT=16: insert 5, then no activity → CHANGE with change_money=5 exactly 16 cycles later. Confirm followed by no insert → IDLE after 16 cycles, no change_req.
- Deassert sys_rst_n asynchronously in DISPENSE with dispense_req high → all outputs at reset values before the next clock edge, with no ack needed.
